// File: rtl/mac16_dot_seq_pkg.sv
// Shared widths and the SB_MAC16 mode used as a 16x16 multiply-accumulator.
// Other MAC16 users import the same constant set so every tile is configured identically.
package mac16_dot_seq_pkg;

    localparam int MAC_W = 32;
    localparam int OP_W  = 16;

    // SB_MAC16 mode: unregistered A/B, registered 16x16 product, registered accumulator on O,
    // adder upper input = accumulator feedback, lower input = 16x16 product.
    localparam logic       MAC16_A_REG                = 1'b0;
    localparam logic       MAC16_B_REG                = 1'b0;
    localparam logic       MAC16_MULT_REG2            = 1'b1;
    localparam logic [1:0] MAC16_TOPOUTPUT_SELECT     = 2'b01;
    localparam logic       MAC16_TOPADDSUB_UPPERINPUT = 1'b0;
    localparam logic [1:0] MAC16_TOPADDSUB_LOWERINPUT = 2'b10;

    function automatic logic [MAC_W-1:0] op_ext(input logic [OP_W-1:0] op, input logic is_signed);
        return is_signed ? {{(MAC_W-OP_W){op[OP_W-1]}}, op} : {{(MAC_W-OP_W){1'b0}}, op};
    endfunction

endpackage

// File: rtl/mac16_dot_seq_dsp.sv
// SB_MAC16 tile behaviour in the package mode: product register then 32-bit accumulator.
// Every register advances only when i_ce is high; i_orst zeroes the accumulator on that edge.
module mac16_dot_seq_dsp
    import mac16_dot_seq_pkg::*;
#(
    parameter bit A_SIGNED = 1'b0,
    parameter bit B_SIGNED = 1'b0
) (
    input  logic             clk,
    input  logic             i_ce,
    input  logic             i_addsub,
    input  logic             i_orst,
    input  logic [OP_W-1:0]  i_a,
    input  logic [OP_W-1:0]  i_b,
    output logic [MAC_W-1:0] o_o
);

    logic [OP_W-1:0]  w_a;
    logic [OP_W-1:0]  w_b;
    logic [MAC_W-1:0] w_mul;
    logic [MAC_W-1:0] w_prod;
    logic [MAC_W-1:0] w_upper;
    logic [MAC_W-1:0] w_lower;
    logic [MAC_W-1:0] w_sum;
    logic [MAC_W-1:0] r_acc;

    generate
        if (MAC16_A_REG) begin : g_a_reg
            logic [OP_W-1:0] r_a;
            always_ff @(posedge clk) if (i_ce) r_a <= i_a;
            assign w_a = r_a;
        end else begin : g_a_thru
            assign w_a = i_a;
        end

        if (MAC16_B_REG) begin : g_b_reg
            logic [OP_W-1:0] r_b;
            always_ff @(posedge clk) if (i_ce) r_b <= i_b;
            assign w_b = r_b;
        end else begin : g_b_thru
            assign w_b = i_b;
        end

        if (MAC16_MULT_REG2) begin : g_prod_reg
            logic [MAC_W-1:0] r_prod;
            always_ff @(posedge clk) if (i_ce) r_prod <= w_mul;
            assign w_prod = r_prod;
        end else begin : g_prod_thru
            assign w_prod = w_mul;
        end
    endgenerate

    // Sign-extending both operands to 32 bits keeps the low 32 product bits exact for every mix.
    assign w_mul   = op_ext(w_a, A_SIGNED) * op_ext(w_b, B_SIGNED);
    assign w_upper = MAC16_TOPADDSUB_UPPERINPUT ? '0 : r_acc;
    assign w_lower = (MAC16_TOPADDSUB_LOWERINPUT == 2'b10) ? w_prod : {w_a, w_b};
    assign w_sum   = i_addsub ? (w_upper - w_lower) : (w_upper + w_lower);

    always_ff @(posedge clk) begin
        if (i_ce) r_acc <= i_orst ? '0 : w_sum;
    end

    always_comb begin
        case (MAC16_TOPOUTPUT_SELECT)
            2'b00:   o_o = w_sum;
            2'b01:   o_o = r_acc;
            default: o_o = w_prod;
        endcase
    end

endmodule

// File: rtl/mac16_dot_seq.sv
// Streaming dot product over one MAC16: last beat accepted at edge k -> res_valid after edge k+3.
// An unconsumed result with the next sum waiting freezes the whole pipeline and drops in_ready.
module mac16_dot_seq
    import mac16_dot_seq_pkg::*;
#(
    parameter bit A_SIGNED = 1'b0,
    parameter bit B_SIGNED = 1'b0
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  in_a,
    input  logic [OP_W-1:0]  in_b,
    input  logic             in_sub,
    input  logic             in_last,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [MAC_W-1:0] res_data
);

    logic             w_en;
    logic             w_take;
    logic [MAC_W-1:0] w_dsp_o;

    logic             r_clr_pend;
    logic [OP_W-1:0]  r_a_q;
    logic [OP_W-1:0]  r_b_q;
    logic             r_l1, r_s1, r_c1;
    logic             r_l2, r_s2, r_c2;
    logic             r_l3;
    logic             r_res_valid;
    logic [MAC_W-1:0] r_res_data;

    assign w_en     = !(r_l3 && r_res_valid && !res_ready);
    assign in_ready = w_en && !r_clr_pend;
    assign w_take   = in_valid && in_ready;

    // The clear slot is the one enabled cycle where in_ready is held low after a vector ends.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_clr_pend <= 1'b1;
            r_a_q      <= '0;
            r_b_q      <= '0;
            r_l1       <= 1'b0;
            r_s1       <= 1'b0;
            r_c1       <= 1'b0;
            r_l2       <= 1'b0;
            r_s2       <= 1'b0;
            r_c2       <= 1'b0;
            r_l3       <= 1'b0;
        end else if (w_en) begin
            r_clr_pend <= w_take && in_last;
            r_a_q      <= w_take ? in_a : '0;
            r_b_q      <= w_take ? in_b : '0;
            r_l1       <= w_take && in_last;
            r_s1       <= w_take && in_sub;
            r_c1       <= r_clr_pend;
            r_l2       <= r_l1;
            r_s2       <= r_s1;
            r_c2       <= r_c1;
            r_l3       <= r_l2;
        end
    end

    // Capture wins over drain so a stalled sum can be taken on the same edge the old one leaves.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
        end else if (w_en && r_l3) begin
            r_res_valid <= 1'b1;
            r_res_data  <= w_dsp_o;
        end else if (res_ready) begin
            r_res_valid <= 1'b0;
        end
    end

    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;

    mac16_dot_seq_dsp #(
        .A_SIGNED (A_SIGNED),
        .B_SIGNED (B_SIGNED)
    ) u_dsp (
        .clk      (clk),
        .i_ce     (w_en),
        .i_addsub (r_s2),
        .i_orst   (r_c2),
        .i_a      (r_a_q),
        .i_b      (r_b_q),
        .o_o      (w_dsp_o)
    );

endmodule

// File: tb/tb_mac16_dot_seq.sv
// Directed and randomised checks of mac16_dot_seq; an unsigned and a signed instance share stimulus.
module tb_mac16_dot_seq;

    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        in_sub;
    logic        in_last;
    logic        res_ready;
    logic        in_ready_u, in_ready_s;
    logic        res_valid_u, res_valid_s;
    logic [31:0] res_data_u, res_data_s;

    int checks = 0;
    int errors = 0;
    bit rnd    = 1'b0;

    logic [31:0] got_u[$];
    logic [31:0] got_s[$];
    logic [31:0] exp_u[$];
    logic [31:0] exp_s[$];

    logic        hold_prev = 1'b0;
    logic [31:0] prev_u;
    logic [31:0] prev_s;

    always #5 clk = ~clk;

    mac16_dot_seq #(.A_SIGNED(1'b0), .B_SIGNED(1'b0)) u_dut_u (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready_u),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_last(in_last),
        .res_valid(res_valid_u), .res_ready(res_ready), .res_data(res_data_u)
    );

    mac16_dot_seq #(.A_SIGNED(1'b1), .B_SIGNED(1'b1)) u_dut_s (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_last(in_last),
        .res_valid(res_valid_s), .res_ready(res_ready), .res_data(res_data_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: dot product from plain integer arithmetic, truncated to 32 bits.
    function automatic logic [31:0] acc_step(input logic [31:0] acc, input logic [15:0] a,
                                             input logic [15:0] b, input bit sub, input bit sgn);
        longint ea, eb, p;
        ea = sgn ? longint'($signed(a)) : longint'(a);
        eb = sgn ? longint'($signed(b)) : longint'(b);
        p  = ea * eb;
        return sub ? acc - p[31:0] : acc + p[31:0];
    endfunction

    task automatic tick();
        if (rnd) res_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send_beat(input logic [15:0] a, input logic [15:0] b,
                             input logic sub, input logic last);
        int n;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_sub   = sub;
        in_last  = last;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready_u && in_ready_s) break;
            n++;
            if (n > 200) break;
            @(posedge clk); #1; tick();
        end
        chk("send_timeout", 32'(n > 200), 32'd0);
        @(posedge clk); #1; tick();
    endtask

    task automatic wait_results(input int n);
        int t;
        t = 0;
        while (got_u.size() < n && t < 3000) begin
            @(posedge clk);
            t++;
        end
        chk("result_count", got_u.size(), n);
    endtask

    task automatic pop_chk(input string tag, input logic [31:0] eu, input logic [31:0] es);
        if (got_u.size() > 0) chk({tag, "_u"}, got_u.pop_front(), eu);
        if (got_s.size() > 0) chk({tag, "_s"}, got_s.pop_front(), es);
    endtask

    // Result handshake collector and hold-stability monitor.
    always @(negedge clk) begin
        if (!resetn) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                chk("hold_vld", {31'd0, res_valid_u && res_valid_s}, 32'd1);
                chk("hold_dat_u", res_data_u, prev_u);
                chk("hold_dat_s", res_data_s, prev_s);
            end
            if (res_valid_u && res_ready) begin
                got_u.push_back(res_data_u);
                got_s.push_back(res_data_s);
            end
            hold_prev = res_valid_u && !res_ready;
            prev_u    = res_data_u;
            prev_s    = res_data_s;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ra, rb;
        logic [31:0] su, ss;
        bit          rsub;
        int          len, gap;

        resetn = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
        in_sub = 1'b0; in_last = 1'b0; res_ready = 1'b1;

        // Reset state, then the post-reset clear slot.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready_u}, 32'd0);
        chk("rst_res_valid", {31'd0, res_valid_u}, 32'd0);
        chk("rst_res_data", res_data_u, 32'd0);
        @(posedge clk); #1; resetn = 1'b1;
        @(negedge clk); chk("clr_after_rst", {31'd0, in_ready_u}, 32'd0);
        @(negedge clk); chk("ready_after_clr", {31'd0, in_ready_u}, 32'd1);
        @(posedge clk); #1;

        // [1,2,3].[4,5,6] with latency and clear-slot gap.
        send_beat(16'd1, 16'd4, 1'b0, 1'b0);
        send_beat(16'd2, 16'd5, 1'b0, 1'b0);
        send_beat(16'd3, 16'd6, 1'b0, 1'b1);
        in_valid = 1'b0;
        @(negedge clk);
        chk("t1_ready_gap", {31'd0, in_ready_u}, 32'd0);
        chk("t1_lat1", {31'd0, res_valid_u}, 32'd0);
        @(negedge clk); chk("t1_ready_back", {31'd0, in_ready_u}, 32'd1);
        @(negedge clk); chk("t1_lat2", {31'd0, res_valid_u}, 32'd0);
        @(negedge clk);
        chk("t1_lat3_vld", {31'd0, res_valid_u}, 32'd1);
        chk("t1_lat3_dat", res_data_u, 32'd32);
        wait_results(1);
        pop_chk("t1", 32'd32, 32'd32);

        // Signed operands with subtraction: (-3)*7 - 2*2.
        @(posedge clk); #1;
        send_beat(16'hFFFD, 16'd7, 1'b0, 1'b0);
        send_beat(16'd2, 16'd2, 1'b1, 1'b1);
        in_valid = 1'b0;
        wait_results(1);
        pop_chk("t2_signed", 32'h0006FFE7, 32'hFFFFFFE7);

        // Wrap-around, then a single-beat vector from a cleared accumulator.
        @(posedge clk); #1;
        send_beat(16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
        send_beat(16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
        send_beat(16'd5, 16'd5, 1'b0, 1'b1);
        in_valid = 1'b0;
        wait_results(2);
        pop_chk("t3_wrap", 32'hFFFC0002, 32'd2);
        pop_chk("t3_single", 32'd25, 32'd25);

        // Back-to-back vectors under result backpressure.
        @(posedge clk); #1;
        res_ready = 1'b0;
        send_beat(16'd1, 16'd4, 1'b0, 1'b0);
        send_beat(16'd2, 16'd5, 1'b0, 1'b0);
        send_beat(16'd3, 16'd6, 1'b0, 1'b1);
        send_beat(16'd5, 16'd5, 1'b0, 1'b1);
        send_beat(16'd7, 16'd1, 1'b0, 1'b1);
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t4_held_vld", {31'd0, res_valid_u}, 32'd1);
            chk("t4_held_dat", res_data_u, 32'd32);
        end
        chk("t4_stall_ready", {31'd0, in_ready_u}, 32'd0);
        @(posedge clk); #1; res_ready = 1'b1;
        wait_results(3);
        pop_chk("t4_first", 32'd32, 32'd32);
        pop_chk("t4_second", 32'd25, 32'd25);
        pop_chk("t4_third", 32'd7, 32'd7);

        // Reset in the middle of a vector discards the partial sum.
        @(posedge clk); #1;
        send_beat(16'd9, 16'd9, 1'b0, 1'b0);
        send_beat(16'd4, 16'd4, 1'b0, 1'b0);
        in_valid = 1'b0;
        resetn = 1'b0;
        @(negedge clk);
        chk("t5_rst_ready", {31'd0, in_ready_u}, 32'd0);
        chk("t5_rst_valid", {31'd0, res_valid_u}, 32'd0);
        repeat (2) @(posedge clk);
        #1; resetn = 1'b1;
        got_u.delete(); got_s.delete();
        send_beat(16'd2, 16'd3, 1'b0, 1'b1);
        in_valid = 1'b0;
        wait_results(1);
        pop_chk("t5_after_rst", 32'd6, 32'd6);

        // Randomised vectors, gaps and res_ready toggling against the reference.
        got_u.delete(); got_s.delete();
        @(posedge clk); #1;
        rnd = 1'b1;
        for (int v = 0; v < 200; v++) begin
            len = $urandom_range(1, 4);
            su  = '0;
            ss  = '0;
            for (int j = 0; j < len; j++) begin
                ra   = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
                rb   = ($urandom_range(0, 3) == 0) ? 16'h8000 : 16'($urandom);
                rsub = 1'($urandom_range(0, 1));
                gap  = $urandom_range(0, 2);
                in_valid = 1'b0;
                repeat (gap) begin @(posedge clk); #1; tick(); end
                su = acc_step(su, ra, rb, rsub, 1'b0);
                ss = acc_step(ss, ra, rb, rsub, 1'b1);
                send_beat(ra, rb, rsub, 1'(j == len - 1));
            end
            exp_u.push_back(su);
            exp_s.push_back(ss);
        end
        in_valid = 1'b0;
        rnd = 1'b0;
        res_ready = 1'b1;
        wait_results(200);
        while (exp_u.size() > 0) pop_chk("rand", exp_u.pop_front(), exp_s.pop_front());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
